// File: rtl/day3_puzzle.sv
// Streaming battery-bank solver: each lane keeps the best k-digit pick
// for k = 1..K and the block registers the sum of every lane's best K-digit value.
module day3_puzzle #(
  parameter int NUM_UNITS = 200,
  parameter int PUZZLE    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [3:0]             next_battery [NUM_UNITS],
  output logic [NUM_UNITS+6:0]   joltage_sum
);

  localparam int K  = (PUZZLE == 1) ? 2 : 12;
  localparam int SW = NUM_UNITS + 7;

  // best_q[u][k] holds best[k+1]; best[0] is the implicit constant 0
  logic [39:0]   best_q [NUM_UNITS][K];
  logic [39:0]   best_d [NUM_UNITS][K];
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_d;

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      for (int k = 0; k < K; k++) begin
        logic [39:0] prev;
        logic [39:0] cand;
        prev = (k == 0) ? 40'd0 : best_q[u][k-1];
        cand = prev * 40'd10 + {36'd0, next_battery[u]};
        best_d[u][k] = best_q[u][k];
        if (en && (next_battery[u] <= 4'd9) && (cand > best_q[u][k])) begin
          best_d[u][k] = cand;
        end
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      sum_d = sum_d + SW'(best_q[u][K-1]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        for (int k = 0; k < K; k++) begin
          best_q[u][k] <= '0;
        end
      end
      sum_q <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        for (int k = 0; k < K; k++) begin
          best_q[u][k] <= best_d[u][k];
        end
      end
      sum_q <= sum_d;
    end
  end

  assign joltage_sum = sum_q;

endmodule

// File: tb/tb_day3_puzzle.sv
// Bench for day3_puzzle: one instance per puzzle variant, shared stimulus,
// greedy subsequence reference model over per-lane digit histories.
module tb_day3_puzzle;

  localparam int N = 200;
  localparam int W = N + 7;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         en    = 1'b0;
  logic [3:0]   nb [N];
  logic [W-1:0] sum1;
  logic [W-1:0] sum2;

  int checks = 0;
  int errors = 0;
  int hist [N][$];

  string banks [4] = '{"987654321111111", "811111111111119",
                       "234234234234278", "818181911112111"};

  always #5 clock = ~clock;

  day3_puzzle #(.NUM_UNITS(N), .PUZZLE(1)) u_p1 (
    .clock(clock), .reset(reset), .en(en),
    .next_battery(nb), .joltage_sum(sum1)
  );

  day3_puzzle #(.NUM_UNITS(N), .PUZZLE(2)) u_p2 (
    .clock(clock), .reset(reset), .en(en),
    .next_battery(nb), .joltage_sum(sum2)
  );

  // Largest value of a length-min(k,n) subsequence, chosen greedily.
  function automatic longint best_of(int i, int k);
    int n = hist[i].size();
    int m = (n < k) ? n : k;
    int st = 0;
    longint v = 0;
    for (int j = 0; j < m; j++) begin
      int bi = st;
      for (int p = st; p <= n - (m - j); p++) begin
        if (hist[i][p] > hist[i][bi]) bi = p;
      end
      v = v * 10 + longint'(hist[i][bi]);
      st = bi + 1;
    end
    return v;
  endfunction

  function automatic longint model_sum(int k);
    longint s = 0;
    for (int i = 0; i < N; i++) s += best_of(i, k);
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset && en) begin
      for (int i = 0; i < N; i++) begin
        if (nb[i] < 4'd10) hist[i].push_back(int'(nb[i]));
      end
    end
    #1;
  endtask

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic settle();
    en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_p1"}, sum1, W'(model_sum(2)));
    chk({tag, "_p2"}, sum2, W'(model_sum(12)));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    en = 1'b0;
    for (int i = 0; i < N; i++) hist[i].delete();
    #1;
    chk("rst_async_p1", sum1, '0);
    chk("rst_async_p2", sum2, '0);
    tick();
    #2;
    reset = 1'b1;
  endtask

  task automatic set_all(logic [3:0] v);
    for (int i = 0; i < N; i++) nb[i] = v;
  endtask

  initial begin
    set_all(4'd15);
    repeat (2) tick();
    chk("reset_p1", sum1, '0);
    chk("reset_p2", sum2, '0);
    reset = 1'b1;
    tick();

    // four example banks, remaining lanes all '0'
    for (int j = 0; j < 15; j++) begin
      set_all(4'd0);
      for (int b = 0; b < 4; b++) nb[b] = 4'(banks[b][j] - "0");
      en = 1'b1;
      tick();
    end
    settle();
    chk("ex_p1", sum1, W'(357));
    chk("ex_p2", sum2, W'(64'd3121910778619));
    chk_model("ex_model");

    // newline terminator is ignored
    set_all(4'd10);
    en = 1'b1;
    tick();
    settle();
    chk("nl_p1", sum1, W'(357));
    chk("nl_p2", sum2, W'(64'd3121910778619));

    // en low holds state whatever the digits
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) nb[i] = 4'($urandom_range(0, 9));
      tick();
    end
    chk("hold_p1", sum1, W'(357));
    chk("hold_p2", sum2, W'(64'd3121910778619));

    // bank "12" with disabled gap cycles
    do_reset();
    set_all(4'd15);
    nb[0] = 4'd1;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) nb[i] = 4'($urandom_range(0, 9));
      tick();
    end
    set_all(4'd15);
    nb[0] = 4'd2;
    en = 1'b1;
    tick();
    settle();
    chk("gap_p1", sum1, W'(12));
    chk("gap_p2", sum2, W'(12));

    // reset mid-bank, then "91"
    set_all(4'd15);
    nb[0] = 4'd9;
    en = 1'b1;
    tick();
    nb[0] = 4'd8;
    tick();
    do_reset();
    set_all(4'd15);
    nb[0] = 4'd9;
    en = 1'b1;
    tick();
    nb[0] = 4'd1;
    tick();
    settle();
    chk("midrst_p1", sum1, W'(91));
    chk("midrst_p2", sum2, W'(91));

    // every lane fifteen nines: full-width sum
    do_reset();
    set_all(4'd9);
    en = 1'b1;
    repeat (15) tick();
    settle();
    chk("nines_p1", sum1, W'(19800));
    chk("nines_p2", sum2, W'(64'd199999999999800));
    chk_model("nines_model");

    // randomized streams with gaps, terminators and uneven lengths
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        en = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++) nb[i] = 4'($urandom_range(0, 15));
        tick();
        if (c == 14) begin
          settle();
          chk_model("rand_mid");
        end
      end
      settle();
      chk_model("rand_end");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
